// File: rtl/calc3_engine_if.sv
// Request/response bundle for calc3_engine: per-port command, operand and tag in,
// ready backpressure and tagged result out. Port p occupies slice [p*W +: W].
interface calc3_engine_if #(
  parameter int PORTS = 4,
  parameter int DW    = 32,
  parameter int TAGW  = 2
);
  logic [4*PORTS-1:0]    req_cmd_in;
  logic [DW*PORTS-1:0]   req_data_in;
  logic [TAGW*PORTS-1:0] req_tag_in;
  logic [PORTS-1:0]      req_ready;
  logic [2*PORTS-1:0]    out_resp;
  logic [DW*PORTS-1:0]   out_data;
  logic [TAGW*PORTS-1:0] out_tag;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  req_ready, out_resp, out_data, out_tag
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output req_ready, out_resp, out_data, out_tag
  );
endinterface

// File: rtl/calc3_engine.sv
// Multi-port tagged arithmetic engine: per-port two-cycle capture FSM and FIFO,
// round-robin dispatch into a shared two-stage execute pipeline, routed responses.
module calc3_engine #(
  parameter int PORTS = 4,
  parameter int DW    = 32,
  parameter int TAGW  = 2,
  parameter int DEPTH = 4
) (
  input  logic            c_clk,
  input  logic            reset,
  calc3_engine_if.slave   if_bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = $clog2(PORTS);
  localparam int SHW = $clog2(DW);
  localparam int EW  = 4 + TAGW + 2 * DW;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;
  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;

  typedef enum logic {S_IDLE, S_OP2} cap_st_t;

  // Returns {resp, data}; data is forced to zero on any error response.
  function automatic logic [DW+1:0] f_exec(input logic [3:0] cmd,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum    = {1'b0, a} + {1'b0, b};
    f_exec = {RESP_ERR, {DW{1'b0}}};
    case (cmd)
      CMD_ADD: if (!sum[DW]) f_exec = {RESP_OK, sum[DW-1:0]};
      CMD_SUB: if (b <= a)   f_exec = {RESP_OK, a - b};
      CMD_SHL: f_exec = {RESP_OK, a << b[SHW-1:0]};
      CMD_SHR: f_exec = {RESP_OK, a >> b[SHW-1:0]};
      default: ;
    endcase
  endfunction

  cap_st_t          r_st     [PORTS];
  cap_st_t          w_st_nxt [PORTS];
  logic [PORTS-1:0] w_ready;
  logic [PORTS-1:0] w_acc;
  logic [PORTS-1:0] w_push;
  logic [PORTS-1:0] w_pop;

  logic [3:0]       r_cmd_c [PORTS];
  logic [TAGW-1:0]  r_tag_c [PORTS];
  logic [DW-1:0]    r_op1_c [PORTS];

  logic [EW-1:0]    r_mem [PORTS][DEPTH];
  logic [AW-1:0]    r_wp  [PORTS];
  logic [AW-1:0]    r_rp  [PORTS];
  logic [AW:0]      r_cnt [PORTS];

  logic [PW-1:0]    r_rr;
  logic [PW-1:0]    w_gnt;
  logic             w_gnt_vld;
  logic [EW-1:0]    w_ent;

  logic             r_vld_p1;
  logic [PW-1:0]    r_port_p1;
  logic [3:0]       r_cmd_p1;
  logic [TAGW-1:0]  r_tag_p1;
  logic [DW-1:0]    r_op1_p1;
  logic [DW-1:0]    r_op2_p1;

  logic             r_vld_p2;
  logic [PW-1:0]    r_port_p2;
  logic [TAGW-1:0]  r_tag_p2;
  logic [1:0]       r_resp_p2;
  logic [DW-1:0]    r_res_p2;

  logic [2*PORTS-1:0]    r_out_resp;
  logic [DW*PORTS-1:0]   r_out_data;
  logic [TAGW*PORTS-1:0] r_out_tag;

  // Capture FSM: ready depends on registered state and count only.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_st_nxt[p] = r_st[p];
      w_ready[p]  = (r_st[p] == S_IDLE) && (r_cnt[p] < (AW+1)'(DEPTH));
      w_acc[p]    = 1'b0;
      w_push[p]   = 1'b0;
      case (r_st[p])
        S_IDLE: begin
          if (if_bus.req_cmd_in[p*4 +: 4] != 4'd0 && w_ready[p]) begin
            w_acc[p]    = 1'b1;
            w_st_nxt[p] = S_OP2;
          end
        end
        S_OP2: begin
          w_push[p]   = 1'b1;
          w_st_nxt[p] = S_IDLE;
        end
        default: w_st_nxt[p] = S_IDLE;
      endcase
    end
  end

  assign if_bus.req_ready = w_ready;

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (reset) r_st[p] <= S_IDLE;
      else       r_st[p] <= w_st_nxt[p];
    end
  end

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (w_acc[p]) begin
        r_cmd_c[p] <= if_bus.req_cmd_in[p*4 +: 4];
        r_tag_c[p] <= if_bus.req_tag_in[p*TAGW +: TAGW];
        r_op1_c[p] <= if_bus.req_data_in[p*DW +: DW];
      end
    end
  end

  // FIFO storage; a push can never find the FIFO full because ready gated the accept.
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (w_push[p])
        r_mem[p][r_wp[p]] <= {r_cmd_c[p], r_tag_c[p], r_op1_c[p],
                              if_bus.req_data_in[p*DW +: DW]};
    end
  end

  always_ff @(posedge c_clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (reset) begin
        r_wp[p]  <= '0;
        r_rp[p]  <= '0;
        r_cnt[p] <= '0;
      end else begin
        if (w_push[p]) r_wp[p] <= r_wp[p] + 1'b1;
        if (w_pop[p])  r_rp[p] <= r_rp[p] + 1'b1;
        case ({w_push[p], w_pop[p]})
          2'b10:   r_cnt[p] <= r_cnt[p] + 1'b1;
          2'b01:   r_cnt[p] <= r_cnt[p] - 1'b1;
          default: r_cnt[p] <= r_cnt[p];
        endcase
      end
    end
  end

  // Round-robin search starting at the pointer, wrapping modulo PORTS.
  always_comb begin : arb
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_pop     = '0;
    for (int i = 0; i < PORTS; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!w_gnt_vld && r_cnt[idx] != '0) begin
        w_gnt_vld = 1'b1;
        w_gnt     = PW'(idx);
      end
    end
    if (w_gnt_vld) w_pop[w_gnt] = 1'b1;
  end

  assign w_ent = r_mem[w_gnt][r_rp[w_gnt]];

  // ---- stage 1: dispatch register ----
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_rr     <= '0;
    end else begin
      r_vld_p1 <= w_gnt_vld;
      if (w_gnt_vld) begin
        if (w_gnt == PW'(PORTS - 1)) r_rr <= '0;
        else                         r_rr <= w_gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (w_gnt_vld) begin
      r_port_p1 <= w_gnt;
      {r_cmd_p1, r_tag_p1, r_op1_p1, r_op2_p1} <= w_ent;
    end
  end

  // ---- stage 2: execute register ----
  always_ff @(posedge c_clk) begin
    if (reset) r_vld_p2 <= 1'b0;
    else       r_vld_p2 <= r_vld_p1;
  end

  always_ff @(posedge c_clk) begin
    if (r_vld_p1) begin
      r_port_p2              <= r_port_p1;
      r_tag_p2               <= r_tag_p1;
      {r_resp_p2, r_res_p2}  <= f_exec(r_cmd_p1, r_op1_p1, r_op2_p1);
    end
  end

  // ---- output register: one-cycle pulse on the originating port ----
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_out_resp <= '0;
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else begin
      r_out_resp <= '0;
      r_out_data <= '0;
      r_out_tag  <= '0;
      if (r_vld_p2) begin
        r_out_resp[int'(r_port_p2)*2    +: 2]    <= r_resp_p2;
        r_out_data[int'(r_port_p2)*DW   +: DW]   <= r_res_p2;
        r_out_tag [int'(r_port_p2)*TAGW +: TAGW] <= r_tag_p2;
      end
    end
  end

  assign if_bus.out_resp = r_out_resp;
  assign if_bus.out_data = r_out_data;
  assign if_bus.out_tag  = r_out_tag;

endmodule

// File: tb/tb_calc3_engine.sv
// Self-checking bench for calc3_engine: vector table, concurrency, backpressure
// and mid-flight reset, with a per-port expected-response scoreboard.
module tb_calc3_engine;
  localparam int PORTS = 4;
  localparam int DW    = 32;
  localparam int TAGW  = 2;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;

  calc3_engine_if #(.PORTS(PORTS), .DW(DW), .TAGW(TAGW)) bus ();

  calc3_engine #(.PORTS(PORTS), .DW(DW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .c_clk  (clk),
    .reset  (rst),
    .if_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]      resp;
    logic [DW-1:0]   data;
    logic [TAGW-1:0] tag;
    int              cyc;
  } exp_t;

  typedef struct {
    int              port;
    logic [3:0]      cmd;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   op1;
    logic [DW-1:0]   op2;
    logic [1:0]      xresp;
    logic [DW-1:0]   xdata;
  } vec_t;

  exp_t sbq [PORTS][$];

  logic [3:0]      cmd_a [PORTS];
  logic [TAGW-1:0] tag_a [PORTS];
  logic [DW-1:0]   op1_a [PORTS];
  logic [DW-1:0]   op2_a [PORTS];
  logic [1:0]      xr_a  [PORTS];
  logic [DW-1:0]   xd_a  [PORTS];
  int              lat_a [PORTS];

  task automatic chk(input string nm, input int port, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s port %0d: got %0h expected %0h (cycle %0d)", nm, port, act, exp, cyc);
  endtask

  // Reference behaviour of the execute unit, written from the operation table.
  function automatic logic [DW+1:0] model(input logic [3:0] c, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW:0] wide;
    int          sh;
    sh = int'(b % DW);
    case (c)
      4'd1: begin
        wide = DW'(a) + (DW+1)'(b);
        if (wide > (DW+1)'({DW{1'b1}})) return {2'd2, {DW{1'b0}}};
        return {2'd1, wide[DW-1:0]};
      end
      4'd2: return (a < b) ? {2'd2, {DW{1'b0}}} : {2'd1, DW'(a - b)};
      4'd5: return {2'd1, DW'(a << sh)};
      4'd6: return {2'd1, DW'(a >> sh)};
      default: return {2'd2, {DW{1'b0}}};
    endcase
  endfunction

  task automatic clear_ports();
    for (int p = 0; p < PORTS; p++) begin
      cmd_a[p] = '0; tag_a[p] = '0; op1_a[p] = '0; op2_a[p] = '0;
      xr_a[p]  = '0; xd_a[p]  = '0; lat_a[p] = -1;
    end
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [TAGW-1:0] t,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input int lat);
    cmd_a[p] = c; tag_a[p] = t; op1_a[p] = a; op2_a[p] = b; lat_a[p] = lat;
    {xr_a[p], xd_a[p]} = model(c, a, b);
  endtask

  // Called just after a falling edge; presents a two-cycle command on every masked port.
  task automatic fire(input logic [PORTS-1:0] mask, output logic [PORTS-1:0] acc);
    exp_t e;
    acc = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (mask[p]) begin
        bus.req_cmd_in[p*4 +: 4]       = cmd_a[p];
        bus.req_tag_in[p*TAGW +: TAGW] = tag_a[p];
        bus.req_data_in[p*DW +: DW]    = op1_a[p];
        if (bus.req_ready[p]) begin
          acc[p] = 1'b1;
          e.resp = xr_a[p]; e.data = xd_a[p]; e.tag = tag_a[p];
          e.cyc  = (lat_a[p] >= 0) ? cyc + 1 + lat_a[p] : -1;
          sbq[p].push_back(e);
        end
      end
    end
    @(posedge clk); @(negedge clk);
    bus.req_cmd_in = '0;
    bus.req_tag_in = ~bus.req_tag_in;
    for (int p = 0; p < PORTS; p++)
      if (mask[p]) bus.req_data_in[p*DW +: DW] = op2_a[p];
    @(posedge clk); @(negedge clk);
    bus.req_data_in = '0;
    bus.req_tag_in  = '0;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_ready"}, -1, 64'(bus.req_ready), 64'({PORTS{1'b1}}));
    chk({nm, "_resp"},  -1, 64'(bus.out_resp), 64'd0);
    chk({nm, "_data"},  -1, 64'(bus.out_data), 64'd0);
    chk({nm, "_tag"},   -1, 64'(bus.out_tag),  64'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int p = 0; p < PORTS; p++) sbq[p].delete();
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic check_drained(input string nm);
    for (int p = 0; p < PORTS; p++) chk(nm, p, 64'(sbq[p].size()), 64'd0);
  endtask

  // Response monitor: every nonzero response must match the oldest expectation of its port.
  logic [1:0]      m_r;
  logic [DW-1:0]   m_d;
  logic [TAGW-1:0] m_t;
  exp_t            m_e;
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < PORTS; p++) begin
        m_r = bus.out_resp[p*2 +: 2];
        m_d = bus.out_data[p*DW +: DW];
        m_t = bus.out_tag[p*TAGW +: TAGW];
        if (m_r != 2'd0) begin
          if (sbq[p].size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_resp port %0d: got resp %0d data %0h tag %0d, expected none (cycle %0d)",
                     p, m_r, m_d, m_t, cyc);
          end else begin
            m_e = sbq[p].pop_front();
            chk("resp", p, 64'(m_r), 64'(m_e.resp));
            chk("data", p, 64'(m_d), 64'(m_e.data));
            chk("tag",  p, 64'(m_t), 64'(m_e.tag));
            if (m_e.cyc >= 0) chk("latency_cycle", p, 64'(cyc), 64'(m_e.cyc));
          end
        end else begin
          chk("idle_zero", p, 64'({m_d, m_t}), 64'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t             vecs [14];
  logic [PORTS-1:0] acc;
  int               ign0, pre0;
  bit               seen_low;

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1;
    bus.req_cmd_in = '0; bus.req_data_in = '0; bus.req_tag_in = '0;

    vecs[0]  = '{0, 4'd1, 2'd2, 32'h0000_0005, 32'h0000_0007, 2'd1, 32'h0000_000C};
    vecs[1]  = '{1, 4'd1, 2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
    vecs[2]  = '{2, 4'd2, 2'd1, 32'h0000_0003, 32'h0000_0005, 2'd2, 32'h0000_0000};
    vecs[3]  = '{3, 4'd2, 2'd3, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0000_0000};
    vecs[4]  = '{0, 4'd5, 2'd0, 32'h8000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002};
    vecs[5]  = '{1, 4'd6, 2'd2, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
    vecs[6]  = '{2, 4'd3, 2'd1, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000};
    vecs[7]  = '{3, 4'd1, 2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF};
    vecs[8]  = '{0, 4'd2, 2'd3, 32'h0000_0010, 32'h0000_0003, 2'd1, 32'h0000_000D};
    vecs[9]  = '{1, 4'd5, 2'd1, 32'h0000_0001, 32'h0000_0020, 2'd1, 32'h0000_0001};
    vecs[10] = '{2, 4'd6, 2'd3, 32'h0000_0001, 32'h0000_0001, 2'd1, 32'h0000_0000};
    vecs[11] = '{3, 4'd7, 2'd2, 32'h0000_0009, 32'h0000_0009, 2'd2, 32'h0000_0000};
    vecs[12] = '{0, 4'hF, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
    vecs[13] = '{1, 4'd1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF};

    @(negedge clk);
    do_reset(3);

    // Single commands with exact 4-edge latency and routing to the issuing port.
    for (int i = 0; i < 14; i++) begin
      clear_ports();
      cmd_a[vecs[i].port] = vecs[i].cmd;
      tag_a[vecs[i].port] = vecs[i].tag;
      op1_a[vecs[i].port] = vecs[i].op1;
      op2_a[vecs[i].port] = vecs[i].op2;
      xr_a[vecs[i].port]  = vecs[i].xresp;
      xd_a[vecs[i].port]  = vecs[i].xdata;
      lat_a[vecs[i].port] = 4;
      fire(PORTS'(1) << vecs[i].port, acc);
      chk("vec_accept", vecs[i].port, 64'(acc), 64'(PORTS'(1) << vecs[i].port));
      repeat (6) @(negedge clk);
      chk("vec_drained", vecs[i].port, 64'(sbq[vecs[i].port].size()), 64'd0);
    end

    // Same-edge commands on all ports: round-robin from pointer 0, twice.
    do_reset(1);
    for (int rep = 0; rep < 2; rep++) begin
      clear_ports();
      for (int p = 0; p < PORTS; p++)
        set_port(p, 4'd1, TAGW'(p + rep), DW'(100 * p + rep), DW'(p + 2), 4 + p);
      fire('1, acc);
      chk("rr_accept", -1, 64'(acc), 64'({PORTS{1'b1}}));
      repeat (10) @(negedge clk);
      check_drained("rr_drained");
    end

    // Sustained load on every port until port 0 backs up; rejected commands must vanish.
    ign0 = 0; pre0 = 0; seen_low = 1'b0;
    for (int r = 0; r < 40; r++) begin
      clear_ports();
      for (int p = 0; p < PORTS; p++)
        set_port(p, (r % 2 == 0) ? 4'd1 : 4'd2, TAGW'(r), DW'($urandom),
                 DW'($urandom_range(0, 1000)), -1);
      fire('1, acc);
      if (!acc[0]) begin
        ign0++;
        seen_low = 1'b1;
      end else if (!seen_low) begin
        pre0++;
      end
    end
    repeat (60) @(negedge clk);
    chk("sat_ready0_dropped", 0, 64'(ign0 > 0), 64'd1);
    chk("sat_accepts_before_drop", 0, 64'(pre0 >= DEPTH), 64'd1);
    check_drained("sat_drained");

    // Reset at E2 with commands queued on every port; nothing may come back.
    clear_ports();
    for (int p = 0; p < PORTS; p++) set_port(p, 4'd1, TAGW'(p), DW'(p), 32'd1, 4);
    fire('1, acc);
    rst = 1'b1;
    for (int p = 0; p < PORTS; p++) sbq[p].delete();
    bus.req_cmd_in[7:4] = 4'd1;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("midreset");
    bus.req_cmd_in = '0;
    rst = 1'b0;
    clear_ports();
    set_port(0, 4'd1, 2'd3, 32'h0000_0010, 32'h0000_0020, 4);
    fire(PORTS'(1), acc);
    chk("post_reset_accept", 0, 64'(acc), 64'(PORTS'(1)));
    repeat (12) @(negedge clk);
    check_drained("post_reset_drained");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
